// File: rtl/input_port_ctrl.sv
// input_port_ctrl: synchronises and debounces the ENTER key, then serves the switch word to the CPU IN instruction.
// Optional macro INPUT_SIGN_EXT_EN selects sign extension of the captured word (default: zero extension).
`default_nettype none

module input_port_ctrl #(
   parameter int DATA_W          = 17,
   parameter int OUT_W           = 32,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              key_n,
   input  logic              in_req,
   output logic [OUT_W-1:0]  in_data,
   output logic              in_ack,
   output logic              in_stall,
   output logic              waiting
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ARMED    = 2'd1,
      ACK      = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0]             r_key_sync;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sw_sync;
   logic                               r_key_db;
   logic [CNT_W-1:0]                   r_cnt;
   logic                               r_press;
   state_t                             r_state;
   logic [OUT_W-1:0]                   r_data;
   logic                               r_ack;
   logic                               r_waiting;

   logic                               w_key_s;
   logic [DATA_W-1:0]                  w_sw_s;
   logic [OUT_W-1:0]                   w_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_sync <= '1;
         r_sw_sync  <= '0;
      end else begin
         r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], key_n};
         r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], sw_data};
      end
   end

   assign w_key_s = r_key_sync[SYNC_STAGES-1];
   assign w_sw_s  = r_sw_sync[SYNC_STAGES-1];

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_db <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_press <= 1'b0;
         if (w_key_s == r_key_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_key_db <= w_key_s;
            r_cnt    <= '0;
            r_press  <= ~w_key_s;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef INPUT_SIGN_EXT_EN
   assign w_ext = {{(OUT_W-DATA_W){w_sw_s[DATA_W-1]}}, w_sw_s};
`else
   assign w_ext = {{(OUT_W-DATA_W){1'b0}}, w_sw_s};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_data    <= '0;
         r_ack     <= 1'b0;
         r_waiting <= 1'b0;
      end else begin
         r_ack     <= 1'b0;
         r_waiting <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_req) begin
                  r_state   <= ARMED;
                  r_waiting <= 1'b1;
               end
            end
            ARMED: begin
               if (!in_req) begin
                  r_state <= IDLE;
               end else if (r_press) begin
                  r_state <= ACK;
                  r_data  <= w_ext;
                  r_ack   <= 1'b1;
               end else begin
                  r_waiting <= 1'b1;
               end
            end
            ACK: begin
               r_state <= WAIT_REL;
            end
            // Hold here until release so one press cannot satisfy a second IN.
            WAIT_REL: begin
               if (r_key_db) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign in_data  = r_data;
   assign in_ack   = r_ack;
   assign waiting  = r_waiting;
   assign in_stall = in_req & ~r_ack;

endmodule

`default_nettype wire

// File: tb/tb_input_port_ctrl.sv
// tb_input_port_ctrl: directed table-driven bench for input_port_ctrl with DEBOUNCE_CYCLES=4.
`default_nettype none

module tb_input_port_ctrl;

   logic        clk;
   logic        rst_n;
   logic [16:0] sw_data;
   logic        key_n;
   logic        in_req;
   logic [31:0] in_data;
   logic        in_ack;
   logic        in_stall;
   logic        waiting;

   int checks    = 0;
   int errors    = 0;
   int ack_cnt   = 0;
   int stall_bad = 0;

   typedef struct {
      logic [16:0] sw;
      logic [31:0] exp_zero;
      logic [31:0] exp_sign;
   } vec_t;

   vec_t tbl [5];

   input_port_ctrl #(
      .DATA_W          (17),
      .OUT_W           (32),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_data  (sw_data),
      .key_n    (key_n),
      .in_req   (in_req),
      .in_data  (in_data),
      .in_ack   (in_ack),
      .in_stall (in_stall),
      .waiting  (waiting)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (in_ack) ack_cnt++;
      if (in_stall !== (in_req & ~in_ack)) stall_bad++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pick(input vec_t v);
`ifdef INPUT_SIGN_EXT_EN
      return v.exp_sign;
`else
      return v.exp_zero;
`endif
   endfunction

   // Press the key, wait for the ack (bounded), check data on the ack cycle, then retire the IN.
   task automatic press_wait(input logic [31:0] exp, input string nm);
      bit got;
      got   = 1'b0;
      key_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (in_ack && !got) begin
            got = 1'b1;
            chk({nm, "_data"}, in_data, exp);
            chk({nm, "_stall"}, {31'd0, in_stall}, 32'd0);
            in_req = 1'b0;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=no_ack required=ack", nm);
      end
   endtask

   initial begin
      int a0;
      tbl[0] = '{17'h000A5, 32'h0000_00A5, 32'h0000_00A5};
      tbl[1] = '{17'h10001, 32'h0001_0001, 32'hFFFF_0001};
      tbl[2] = '{17'h1FFFF, 32'h0001_FFFF, 32'hFFFF_FFFF};
      tbl[3] = '{17'h00000, 32'h0000_0000, 32'h0000_0000};
      tbl[4] = '{17'h0FFFF, 32'h0000_FFFF, 32'h0000_FFFF};

      rst_n   = 1'b0;
      in_req  = 1'b1;
      key_n   = 1'b1;
      sw_data = 17'h1ABCD;
      tick(3);
      chk("reset_data", in_data, 32'd0);
      chk("reset_ack", {31'd0, in_ack}, 32'd0);
      chk("reset_waiting", {31'd0, waiting}, 32'd0);
      chk("reset_stall", {31'd0, in_stall}, 32'd1);
      rst_n  = 1'b1;
      in_req = 1'b0;
      tick(2);

      for (int i = 0; i < 5; i++) begin
         a0      = ack_cnt;
         sw_data = tbl[i].sw;
         in_req  = 1'b1;
         tick(3);
         chk("vec_waiting", {31'd0, waiting}, 32'd1);
         press_wait(pick(tbl[i]), "vec");
         key_n = 1'b1;
         tick(10);
         chk("vec_ack_count", ack_cnt - a0, 32'd1);
         chk("vec_stall_rule", stall_bad, 32'd0);
      end

      a0      = ack_cnt;
      sw_data = 17'h00123;
      in_req  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         key_n = ~key_n;
         tick(2);
      end
      key_n = 1'b1;
      tick(8);
      chk("bounce_no_ack", ack_cnt - a0, 32'd0);
      chk("bounce_stall", {31'd0, in_stall}, 32'd1);
      chk("bounce_waiting", {31'd0, waiting}, 32'd1);
      chk("bounce_data_hold", in_data, 32'h0000_FFFF);

      in_req = 1'b0;
      key_n  = 1'b0;
      tick(10);
      a0      = ack_cnt;
      sw_data = 17'h00055;
      in_req  = 1'b1;
      tick(10);
      chk("held_no_ack", ack_cnt - a0, 32'd0);
      chk("held_stall", {31'd0, in_stall}, 32'd1);
      key_n = 1'b1;
      tick(8);
      press_wait(32'h0000_0055, "held");

      tick();
      a0      = ack_cnt;
      sw_data = 17'h000AA;
      in_req  = 1'b1;
      tick(10);
      chk("second_no_ack", ack_cnt - a0, 32'd0);
      chk("second_stall", {31'd0, in_stall}, 32'd1);
      chk("second_data_hold", in_data, 32'h0000_0055);
      key_n = 1'b1;
      tick(8);
      press_wait(32'h0000_00AA, "second");
      key_n = 1'b1;
      tick(10);
      chk("second_ack_count", ack_cnt - a0, 32'd1);

      a0      = ack_cnt;
      sw_data = 17'h01234;
      in_req  = 1'b1;
      tick(4);
      chk("flush_armed", {31'd0, waiting}, 32'd1);
      in_req = 1'b0;
      tick(2);
      chk("flush_idle", {31'd0, waiting}, 32'd0);
      key_n = 1'b0;
      tick(10);
      key_n = 1'b1;
      tick(10);
      chk("flush_no_ack", ack_cnt - a0, 32'd0);
      chk("flush_data_hold", in_data, 32'h0000_00AA);

      sw_data = 17'h00077;
      in_req  = 1'b1;
      tick(3);
      press_wait(32'h0000_0077, "rstmid");
      chk("rstmid_before", in_data, 32'h0000_0077);
      rst_n = 1'b0;
      #2;
      chk("rstmid_data", in_data, 32'd0);
      chk("rstmid_ack", {31'd0, in_ack}, 32'd0);
      chk("rstmid_waiting", {31'd0, waiting}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      key_n = 1'b1;
      tick(10);
      chk("rstmid_after_data", in_data, 32'd0);
      chk("rstmid_after_waiting", {31'd0, waiting}, 32'd0);
      chk("final_stall_rule", stall_bad, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
